// File: rtl/packet_sink.sv
// packet_sink: four-phase handshake receiver that captures packets in order into a
// 32-entry buffer with a registered read port. Define PACKET_SINK_SYNC_EN for a 2-flop Send_in synchronizer.
module packet_sink #(
    parameter int WIDTH      = 38,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  Send_in,
    input  logic [WIDTH-1:0]      PACKET_IN,
    output logic                  Ack_out,
    input  logic                  CLEAR,
    input  logic [DEPTH_LOG2-1:0] RD_ADDR,
    output logic [WIDTH-1:0]      RD_DATA,
    output logic [DEPTH_LOG2:0]   COUNT_OUT,
    output logic                  FULL_OUT
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACK   = 2'd1;
    localparam logic [1:0] STALL = 2'd2;

    logic req_s;

`ifdef PACKET_SINK_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values;
    // with blocking assignments sync_q2 would copy Send_in in a single edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= Send_in;
            sync_q2 <= sync_q1;
        end
    end

    assign req_s = sync_q2;
`else
    assign req_s = Send_in;
`endif

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic                  full;
    logic                  room;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [WIDTH-1:0]      rd_data;

    // A CLEAR in the capture cycle frees the buffer at once, so the packet goes to entry 0.
    assign full    = (count == CNT_W'(DEPTH));
    assign room    = !full || CLEAR;
    assign wr_addr = CLEAR ? '0 : count[DEPTH_LOG2-1:0];

    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (req_s) begin
                    if (room) begin
                        wr_en     = 1'b1;
                        state_nxt = ACK;
                    end else begin
                        state_nxt = STALL;
                    end
                end
            end
            STALL: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                end else if (room) begin
                    wr_en     = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = (CLEAR ? '0 : count) + CNT_W'(wr_en);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // NOTE: the buffer has no reset so it maps onto RAM; only the read register is cleared.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= PACKET_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[RD_ADDR];
        end
    end

    assign Ack_out   = (state == ACK);
    assign RD_DATA   = rd_data;
    assign COUNT_OUT = count;
    assign FULL_OUT  = full;

endmodule

// File: tb/tb_packet_sink.sv
// Scoreboard bench for packet_sink: driver pushes expectations, monitor compares on Ack_out rise / read return.
module tb_packet_sink;

    localparam int WIDTH      = 38;
    localparam int DEPTH_LOG2 = 5;
    localparam int DEPTH      = 32;
`ifdef PACKET_SINK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic                  CLK = 1'b0;
    logic                  RST_N;
    logic                  Send_in;
    logic [WIDTH-1:0]      PACKET_IN;
    logic                  Ack_out;
    logic                  CLEAR;
    logic [DEPTH_LOG2-1:0] RD_ADDR;
    logic [WIDTH-1:0]      RD_DATA;
    logic [DEPTH_LOG2:0]   COUNT_OUT;
    logic                  FULL_OUT;

    packet_sink #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .CLK(CLK), .RST_N(RST_N), .Send_in(Send_in), .PACKET_IN(PACKET_IN),
        .Ack_out(Ack_out), .CLEAR(CLEAR), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
        .COUNT_OUT(COUNT_OUT), .FULL_OUT(FULL_OUT)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: buffer contents, written flags and occupancy.
    logic [WIDTH-1:0] model_mem [DEPTH];
    bit               written   [DEPTH];
    int               model_cnt = 0;

    int               exp_count [$];
    logic [WIDTH-1:0] exp_rd    [$];
    bit               rd_req = 1'b0;
    bit               rd_req_d = 1'b0;
    bit               ack_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model of one accepted packet: a full buffer only accepts after a CLEAR empties it.
    task automatic model_capture(input logic [WIDTH-1:0] pkt);
        model_mem[model_cnt] = pkt;
        written[model_cnt]   = 1'b1;
        model_cnt++;
        exp_count.push_back(model_cnt);
    endtask

    always @(posedge CLK) rd_req_d <= rd_req;

    always @(negedge CLK) begin
        if (Ack_out && !ack_prev) begin
            if (exp_count.size() == 0) check("unexpected_ack", 64'(1), 64'(0));
            else check("count_at_ack", 64'(COUNT_OUT), 64'(exp_count.pop_front()));
        end
        ack_prev = Ack_out;
        if (rd_req_d) begin
            if (exp_rd.size() == 0) check("unexpected_read", 64'(1), 64'(0));
            else check("rd_data", 64'(RD_DATA), 64'(exp_rd.pop_front()));
        end
    end

    // Counts posedges until Ack_out equals lvl (checked 1 time unit after each edge).
    task automatic wait_ack(input logic lvl, input int max_cyc, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge CLK);
            #1;
            n++;
            if (Ack_out === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic handshake(input logic [WIDTH-1:0] pkt);
        int n;
        bit ok;
        @(negedge CLK);
        PACKET_IN = pkt;
        Send_in   = 1'b1;
        model_capture(pkt);
        wait_ack(1'b1, 20, n, ok);
        check("ack_rise_seen", 64'(ok), 64'(1));
        check("ack_rise_latency", 64'(n), 64'(LAT));
        @(negedge CLK);
        Send_in = 1'b0;
        wait_ack(1'b0, 20, n, ok);
        check("ack_fall_seen", 64'(ok), 64'(1));
        check("ack_fall_latency", 64'(n), 64'(LAT));
    endtask

    task automatic do_read(input int addr);
        @(negedge CLK);
        RD_ADDR = DEPTH_LOG2'(addr);
        exp_rd.push_back(model_mem[addr]);
        rd_req = 1'b1;
        @(negedge CLK);
        rd_req = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge CLK);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        model_cnt = 0;
    endtask

    function automatic logic [WIDTH-1:0] rand_pkt();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[WIDTH-1:0];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;
        logic [WIDTH-1:0] pkt;

        RST_N = 1'b0; Send_in = 1'b0; PACKET_IN = '0; CLEAR = 1'b0; RD_ADDR = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_ack", 64'(Ack_out), 64'(0));
        check("reset_count", 64'(COUNT_OUT), 64'(0));
        check("reset_full", 64'(FULL_OUT), 64'(0));
        check("reset_rd_data", 64'(RD_DATA), 64'(0));
        @(negedge CLK);
        RST_N = 1'b1;

        // Single directed handshake and read-back.
        handshake(38'h2A_DEAD_BEEF);
        check("count_after_first", 64'(COUNT_OUT), 64'(1));
        do_read(0);

        // Fill with 0..31.
        pulse_clear();
        for (int i = 0; i < DEPTH; i++) handshake(WIDTH'(i));
        #1;
        check("full_after_fill", 64'(FULL_OUT), 64'(1));
        check("count_after_fill", 64'(COUNT_OUT), 64'(32));
        for (int i = 0; i < DEPTH; i++) do_read(i);

        // Request while full stalls until CLEAR.
        pkt = rand_pkt();
        @(negedge CLK);
        PACKET_IN = pkt;
        Send_in   = 1'b1;
        repeat (LAT + 5) @(posedge CLK);
        #1;
        check("stall_no_ack", 64'(Ack_out), 64'(0));
        check("stall_count", 64'(COUNT_OUT), 64'(32));
        model_cnt = 0;
        model_capture(pkt);
        @(negedge CLK);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        wait_ack(1'b1, 20, n, ok);
        if (!Ack_out) check("stall_ack_after_clear", 64'(Ack_out), 64'(1));
        check("stall_count_after_clear", 64'(COUNT_OUT), 64'(1));
        @(negedge CLK);
        Send_in = 1'b0;
        wait_ack(1'b0, 20, n, ok);
        check("stall_release", 64'(ok), 64'(1));
        do_read(0);

        // CLEAR on the capture edge: entry 0 gets the packet, count becomes 1.
        handshake(rand_pkt());
        pkt = rand_pkt();
        @(negedge CLK);
        PACKET_IN = pkt;
        Send_in   = 1'b1;
        model_cnt = 0;
        model_capture(pkt);
        for (int i = 1; i < LAT; i++) @(negedge CLK);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        check("clear_capture_ack", 64'(Ack_out), 64'(1));
        check("clear_capture_count", 64'(COUNT_OUT), 64'(1));
        Send_in = 1'b0;
        wait_ack(1'b0, 20, n, ok);
        do_read(0);

        // Long request: exactly one write.
        pkt = rand_pkt();
        @(negedge CLK);
        PACKET_IN = pkt;
        Send_in   = 1'b1;
        model_capture(pkt);
        repeat (50) @(posedge CLK);
        #1;
        check("long_req_count", 64'(COUNT_OUT), 64'(model_cnt));
        @(negedge CLK);
        Send_in = 1'b0;
        wait_ack(1'b0, 20, n, ok);
        do_read(model_cnt - 1);

        // Reset mid-handshake, then recapture of the still-offered packet.
        pkt = rand_pkt();
        @(negedge CLK);
        PACKET_IN = pkt;
        Send_in   = 1'b1;
        model_capture(pkt);
        wait_ack(1'b1, 20, n, ok);
        check("pre_reset_ack", 64'(Ack_out), 64'(1));
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("async_reset_ack", 64'(Ack_out), 64'(0));
        check("async_reset_count", 64'(COUNT_OUT), 64'(0));
        model_cnt = 0;
        model_capture(pkt);
        @(negedge CLK);
        RST_N = 1'b1;
        wait_ack(1'b1, 20, n, ok);
        check("recapture_ack", 64'(ok), 64'(1));
        check("recapture_count", 64'(COUNT_OUT), 64'(1));
        @(negedge CLK);
        Send_in = 1'b0;
        wait_ack(1'b0, 20, n, ok);
        do_read(0);

        // Randomized handshakes, clears and reads.
        for (int it = 0; it < 60; it++) begin
            if (model_cnt == DEPTH || $urandom_range(9) == 0) pulse_clear();
            handshake(rand_pkt());
            for (int r = 0; r < 2; r++) begin
                int a;
                a = $urandom_range(DEPTH - 1);
                if (written[a]) do_read(a);
            end
            #1;
            check("rand_full", 64'(FULL_OUT), 64'(model_cnt == DEPTH));
        end

        repeat (4) @(negedge CLK);
        check("ack_queue_drained", 64'(exp_count.size()), 64'(0));
        check("read_queue_drained", 64'(exp_rd.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/packet_sink.md
# packet_sink

Receiving end of the packet fetch interface. Accepts 38-bit packets offered with a four-phase Send_in/Ack_out handshake and writes them, in order, into a 32-entry capture buffer. Software or the bench reads the buffer back through a registered read port. Sits downstream of the packet fetch unit as its consumer and loopback checker.

## Interface
Parameters:
- WIDTH, 38, packet width in bits
- DEPTH_LOG2, 5, log2 of buffer depth (32 entries)

Ports:
- CLK  in  1  single system clock, rising edge
- RST_N  in  1  reset; asynchronous, active-low
- Send_in  in  1  request; high means PACKET_IN is valid (asynchronous to CLK)
- PACKET_IN  in  WIDTH  packet data; stable from Send_in rise until Ack_out rise
- Ack_out  out  1  acknowledge; four-phase return
- CLEAR  in  1  synchronous one-cycle pulse; empties the buffer
- RD_ADDR  in  DEPTH_LOG2  buffer read index
- RD_DATA  out  WIDTH  registered buffer contents at RD_ADDR
- COUNT_OUT  out  DEPTH_LOG2+1  number of stored packets, 0..32
- FULL_OUT  out  1  high when COUNT_OUT == 32

## Operation
- Send_in passes through a request synchronizer; its output is req_s.
- FSM states and transitions:
  - IDLE: go to ACK when req_s = 1 and not full. On that transition, write PACKET_IN to mem[COUNT_OUT[4:0]], increment COUNT_OUT, and set Ack_out = 1.
  - IDLE, req_s = 1 and full: go to STALL. Ack_out stays 0 and nothing is written.
  - STALL: go to ACK with the same write action once the buffer is no longer full (after CLEAR).
  - ACK: hold Ack_out = 1 until req_s = 0, then clear Ack_out and go to IDLE.
- Exactly one write per handshake, regardless of how long Send_in stays high.
- CLEAR sets COUNT_OUT to 0 and FULL_OUT to 0. Memory contents are untouched.
  - In ACK, CLEAR does not abort the handshake.
  - CLEAR in the same cycle as the write transition: the write goes to entry 0 and COUNT_OUT becomes 1.
- FULL_OUT is derived from the COUNT_OUT register (registered).
- RD_DATA is updated every cycle from mem[RD_ADDR]. Reading an address not yet written returns stale or undefined contents.
- Reset values: Ack_out 0, COUNT_OUT 0, FULL_OUT 0, RD_DATA 0, FSM in IDLE, synchronizer flops 0. Memory is not reset.
- RST_N asserted mid-handshake: Ack_out drops immediately. After release, if Send_in is still high, the packet is captured again as a new handshake.

## Timing
- Request latency (sync on): Ack_out rises on the 3rd CLK edge after Send_in rises. That is 2 edges through the synchronizer plus 1 FSM edge.
- Release latency: Ack_out falls on the 3rd CLK edge after Send_in falls.
- COUNT_OUT and the memory write take effect on the same edge that raises Ack_out.
- Read latency: RD_DATA reflects RD_ADDR 1 cycle later. A write and a read of the same address on the same edge returns the old data.
- Minimum handshake period: 6 CLK cycles.
- Send_in pulses shorter than 2 CLK periods may be missed. This is legal only if the sender also waits for Ack_out.

## Configuration
- PACKET_SINK_SYNC_EN
  - Defined: 2-flop synchronizer on Send_in; request and release latencies are 3 cycles as above.
  - Undefined: Send_in is used directly as req_s. Use only when the sender is on CLK. Request and release latencies become 1 cycle; all other behaviour is identical.

## Test plan
- Reset, then one handshake with PACKET_IN = 38'h2A_DEAD_BEEF, sync on:
  - Ack_out rises 3 edges after Send_in and COUNT_OUT = 1.
  - RD_ADDR = 0 returns 38'h2A_DEAD_BEEF one cycle later.
  - Ack_out falls 3 edges after Send_in falls.
- 32 back-to-back handshakes with packets 0..31:
  - FULL_OUT = 1 and COUNT_OUT = 32.
  - mem[i] = i for all i.
- 33rd request while full: Ack_out stays 0 and the FSM is in STALL. Pulse CLEAR: the packet lands in entry 0, COUNT_OUT = 1, Ack_out rises.
- CLEAR on the same cycle as a capture: COUNT_OUT = 1 and entry 0 holds the new packet.
- Hold Send_in high for 50 cycles: exactly one write; COUNT_OUT increments by 1 only.
- Assert RST_N low while Ack_out = 1 and Send_in is high: Ack_out = 0 asynchronously and COUNT_OUT = 0. After release the packet is recaptured and COUNT_OUT = 1.
